// File: rtl/mul_unit.sv
// Iterative 64x64 radix-2 shift-add multiplier (MUL/SMULH/UMULH) producing a
// register-file write-back request; destination X31 never gets a write enable.
module mul_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        we,
  output logic [4:0]  wa,
  output logic [63:0] wd
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned PLEN  = 2 * XLEN;
  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0]     OP_SMULH = 2'b01;
  localparam logic [1:0]     OP_UMULH = 2'b10;
  localparam logic [AW-1:0]  REG_XZR  = AW'(31);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [PLEN-1:0]  prod_q, prod_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             we_q, we_d;
  logic [AW-1:0]    wa_q, wa_d;
  logic [XLEN-1:0]  wd_q, wd_d;

  logic             is_smulh;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [PLEN-1:0]  prod_fixed;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  // Operand conditioning: SMULH multiplies magnitudes, sign is restored in FIX.
  // The magnitude of -2^63 is 2^63, which still fits as an unsigned 64-bit value.
  always_comb begin
    is_smulh   = (op == OP_SMULH);
    a_mag      = (is_smulh && a[XLEN-1]) ? XLEN'(~a + XLEN'(1)) : a;
    b_mag      = (is_smulh && b[XLEN-1]) ? XLEN'(~b + XLEN'(1)) : b;
    prod_fixed = sign_q ? PLEN'(~prod_q + PLEN'(1)) : prod_q;
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          wa_d     = rd;
          sign_d   = is_smulh & (a[XLEN-1] ^ b[XLEN-1]);
          mcand_d  = {{XLEN{1'b0}}, a_mag};
          mplier_d = b_mag;
          prod_d   = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end

      // One multiplier bit per cycle, LSB first
      S_RUN: begin
        if (mplier_q[0]) begin
          prod_d = PLEN'(prod_q + mcand_q);
        end
        mcand_d  = PLEN'(mcand_q << 1);
        mplier_d = mplier_q >> 1;
        cnt_d    = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if ((op_q == OP_SMULH) || (op_q == OP_UMULH)) begin
          wd_d = prod_fixed[PLEN-1:XLEN];
        end else begin
          wd_d = prod_fixed[XLEN-1:0];
        end
        done_d  = 1'b1;
        we_d    = (wa_q != REG_XZR);
        state_d = S_DONE;
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign we   = we_q;
  assign wa   = wa_q;
  assign wd   = wd_q;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: driver pushes expected write-backs computed with
// plain 128-bit arithmetic; a negedge monitor checks every cycle's outputs.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic [4:0]  rd;
  logic        busy, done, we;
  logic [4:0]  wa;
  logic [63:0] wd;

  mul_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd(rd),
    .busy(busy), .done(done), .we(we), .wa(wa), .wd(wd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc = -1000;
  bit   active  = 1'b0;
  bit   mon_en  = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Reference: full-precision products, no iteration
  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] x,
                                          input logic [63:0] y);
    logic signed [127:0] sp;
    logic [127:0]        up;
    sp = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
    up = {64'd0, x} * {64'd0, y};
    case (o)
      2'b01:   return sp[127:64];
      2'b10:   return up[127:64];
      default: return up[63:0];
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic exp_busy;
      exp_busy = active && (cyc > acc_cyc) && (cyc <= acc_cyc + 66);
      chk("busy", 64'(busy), 64'(exp_busy));
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("done", 64'(done), 64'd1);
        chk("we", 64'(we), 64'(e.we));
        chk("wa", 64'(wa), 64'(e.wa));
        chk("wd", wd, e.wd);
      end else begin
        chk("done_idle", 64'(done), 64'd0);
        chk("we_idle", 64'(we), 64'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic [4:0] r, input bit push);
    exp_t e;
    op = o; a = x; b = y; rd = r; start = 1'b1;
    if (push) begin
      acc_cyc = cyc;
      active  = 1'b1;
      e.due = cyc + 66;
      e.wa  = r;
      e.wd  = ref_mul(o, x, y);
      e.we  = (r != 5'd31);
      sb.push_back(e);
    end
    step(1);
    start = 1'b0;
    op = 2'($urandom);
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    rd = 5'($urandom);
  endtask

  // Issue and wait until the earliest next acceptance cycle
  task automatic run(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                     input logic [4:0] r);
    issue(o, x, y, r, 1'b1);
    step(66);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'h8000_0000_0000_0000;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rd = '0;
    step(3);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wa", 64'(wa), 64'd0);
    chk("rst_wd", wd, 64'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    step(2);

    run(2'b00, 64'd3, 64'd5, 5'd2);
    run(2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd9);
    run(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4);
    run(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5);
    run(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd6);
    run(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7);
    run(2'b00, 64'd7, 64'd6, 5'd31);
    run(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd1);

    // Starts while busy are dropped; the one at acc+67 is accepted
    issue(2'b00, 64'd11, 64'd13, 5'd3, 1'b1);
    step(9);
    issue(2'b10, 64'd99, 64'd77, 5'd8, 1'b0);
    step(55);
    issue(2'b01, 64'd55, 64'd44, 5'd10, 1'b0);
    run(2'b00, 64'd100, 64'd200, 5'd12);

    // Reset in the middle abandons the operation
    issue(2'b00, 64'd9, 64'd9, 5'd14, 1'b1);
    step(29);
    reset = 1'b1;
    step(1);
    reset  = 1'b0;
    active = 1'b0;
    sb.delete();
    step(2);
    run(2'b00, 64'd2, 64'd2, 5'd15);

    for (int i = 0; i < 40; i++) begin
      run(2'($urandom), pick(), pick(), 5'($urandom_range(0, 31)));
    end

    step(5);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative 64-bit integer multiplier sitting directly downstream of the LEGv8 register file: it consumes the two read-port operands (rd1, rd2), computes MUL, SMULH or UMULH over 66 cycles, and returns the result as a write-back request (we, wa, wd) that drives the register file's write port (we3, wa3, wd3). Destination X31 (XZR) is never written; the request is suppressed here.

## Interface
- No parameters; width fixed at 64 bits, register address at 5 bits.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  2'b00 MUL (low 64 bits), 2'b01 SMULH (signed high 64), 2'b10 UMULH (unsigned high 64), 2'b11 treated as MUL
- a  input  64  multiplicand (from rd1)
- b  input  64  multiplier (from rd2)
- rd  input  5  destination register
- busy  output  1  high from the cycle after acceptance through the DONE cycle
- done  output  1  one-cycle completion pulse
- we  output  1  write enable to register file; equals done when wa != 31, else 0
- wa  output  5  latched destination
- wd  output  64  result; valid while done=1

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on start=1, latch op, rd, |a|, |b| (absolute values only for SMULH; raw otherwise), sign = a[63]^b[63] for SMULH else 0; clear 128-bit product, load counter to 0; go RUN.
- RUN: radix-2 shift-add, one multiplier bit per cycle (LSB first), 128-bit accumulator; counter 0..63; on counter==63 go FIX.
- FIX: if sign, product = two's complement of 128-bit product; select product[63:0] for MUL, product[127:64] for SMULH/UMULH into wd; go DONE.
- DONE: done=1, we=(wa!=5'd31), busy=1; next cycle IDLE unconditionally.
- start in RUN/FIX/DONE is ignored (no queueing); upstream must hold off while busy.
- Operands a, b, rd, op may change freely after acceptance; only latched copies are used.
- Arithmetic modulo 2^128; |−2^63| = 2^63 handled as unsigned 64-bit magnitude (SMULH of 0x8000…0 × 0x8000…0 = 0x4000_0000_0000_0000).
- reset in any state: return to IDLE next edge, abandon operation, no write-back.

## Timing
- Reset values: busy=0, done=0, we=0, wa=0, wd=0, state IDLE.
- start high in cycle 0 → RUN cycles 1–64 → FIX cycle 65 → DONE cycle 66 (done, we, wd valid) → IDLE cycle 67; earliest next acceptance is start high in cycle 67.
- Latency 66 cycles start-to-done; throughput one op per 67 cycles.
- busy high cycles 1–66; low in cycle 0 and from cycle 67.
- done and we are single-cycle pulses; wd and wa hold their values after DONE until the next FIX/acceptance.
- Write lands in the register file at the clk edge ending cycle 66; same-cycle reads of that register see the old value.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then MUL a=3, b=5, rd=2 → cycle 66 done=1, we=1, wa=2, wd=15; busy=1 exactly cycles 1–66.
- MUL a=0xFFFF_FFFF_FFFF_FFFE (−2), b=3, rd=9 → wd=0xFFFF_FFFF_FFFF_FFFA; UMULH a=b=0xFFFF_FFFF_FFFF_FFFF → wd=0xFFFF_FFFF_FFFF_FFFE.
- SMULH a=−1, b=−1 → wd=0; SMULH a=−1, b=1 → wd=0xFFFF_FFFF_FFFF_FFFF; SMULH a=b=0x8000_0000_0000_0000 → wd=0x4000_0000_0000_0000.
- MUL a=7, b=6, rd=31 → done=1 in cycle 66, we=0.
- start pulsed in cycles 10 and 66 with different operands → ignored; result matches first op; start in cycle 67 accepted, done in cycle 133.
- reset asserted in cycle 30 → cycle 31 busy=0; no done/we for the abandoned op; fresh MUL 2×2 afterwards → wd=4.
